// File: rtl/cache_pkg.sv
// Shared types and default widths for the direct-mapped cache controller.
package cache_pkg;

   localparam int NUM_SETS_DEF   = 4;
   localparam int SET_SIZE_DEF   = 2;
   localparam int ADDR_WIDTH_DEF = 32;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      WRITEBACK_REQ,
      WRITEBACK_WAIT,
      FILL_REQ,
      FILL_WAIT,
      RESPOND
   } cache_state_e;

   typedef enum logic {
      SRC_CPU = 1'b0,
      SRC_MEM = 1'b1
   } data_src_e;

endpackage

// File: rtl/cache_controller.sv
// Request sequencer for a direct-mapped, one-word-per-line cache.
// CACHE_WRITEBACK_EN selects the write-back build; otherwise read-only.
module cache_controller
   import cache_pkg::*;
#(
   parameter int NUM_SETS   = NUM_SETS_DEF,
   parameter int SET_SIZE   = SET_SIZE_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   localparam int TAG_SIZE  = ADDR_WIDTH - SET_SIZE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic                  rsp_err,
   output logic [SET_SIZE-1:0]   set,
   output logic [TAG_SIZE-1:0]   tag,
   output logic                  clear_selected_valid_bit,
   output logic                  finish_new_line_install,
   output logic                  clear_selected_dirty_bit,
   output logic                  set_selected_dirty_bit,
   input  logic                  valid_block_match,
   input  logic                  valid_dirty_bit,
   input  logic [TAG_SIZE-1:0]   selected_tag,
   output logic                  data_wr_en,
   output logic                  data_wr_src,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_we,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_rsp_valid
);

   cache_state_e          state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic                  err_q;
   data_src_e             src;
   logic                  unused_ok;

   // Store data goes straight from the CPU port into the data array.
   assign unused_ok = ^{req_wdata, valid_dirty_bit, selected_tag};

   assign set         = addr_q[SET_SIZE-1:0];
   assign tag         = addr_q[ADDR_WIDTH-1:SET_SIZE];
   assign data_wr_src = src;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         addr_q <= '0;
         we_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q <= req_addr;
                  we_q   <= req_we;
                  err_q  <= 1'b0;
                  state  <= LOOKUP;
               end
            end
            LOOKUP: begin
`ifdef CACHE_WRITEBACK_EN
               if (valid_block_match)
                  state <= RESPOND;
               else if (valid_dirty_bit)
                  state <= WRITEBACK_REQ;
               else
                  state <= FILL_REQ;
`else
               if (we_q) begin
                  err_q <= 1'b1;
                  state <= RESPOND;
               end else if (valid_block_match)
                  state <= RESPOND;
               else
                  state <= FILL_REQ;
`endif
            end
            WRITEBACK_REQ:
               if (mem_req_ready) state <= WRITEBACK_WAIT;
            WRITEBACK_WAIT:
               if (mem_rsp_valid) state <= FILL_REQ;
            FILL_REQ:
               if (mem_req_ready) state <= FILL_WAIT;
            // The replayed lookup is guaranteed to hit.
            FILL_WAIT:
               if (mem_rsp_valid) state <= LOOKUP;
            RESPOND: begin
               state  <= IDLE;
               addr_q <= '0;
               we_q   <= 1'b0;
               err_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      req_ready                = (state == IDLE);
      rsp_valid                = 1'b0;
      rsp_err                  = 1'b0;
      clear_selected_valid_bit = 1'b0;
      finish_new_line_install  = 1'b0;
      clear_selected_dirty_bit = 1'b0;
      set_selected_dirty_bit   = 1'b0;
      data_wr_en               = 1'b0;
      src                      = SRC_CPU;
      mem_req_valid            = 1'b0;
      mem_req_we               = 1'b0;
      mem_req_addr             = '0;
      unique case (state)
         LOOKUP: begin
`ifdef CACHE_WRITEBACK_EN
            if (valid_block_match && we_q) begin
               data_wr_en             = 1'b1;
               set_selected_dirty_bit = 1'b1;
            end else if (!valid_block_match && !valid_dirty_bit)
               clear_selected_valid_bit = 1'b1;
`else
            if (!we_q && !valid_block_match)
               clear_selected_valid_bit = 1'b1;
`endif
         end
         WRITEBACK_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_we    = 1'b1;
            mem_req_addr  = {selected_tag, set};
         end
         WRITEBACK_WAIT:
            clear_selected_valid_bit = mem_rsp_valid;
         FILL_REQ: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = addr_q;
         end
         FILL_WAIT: begin
            if (mem_rsp_valid) begin
               data_wr_en              = 1'b1;
               src                     = SRC_MEM;
               finish_new_line_install = 1'b1;
`ifdef CACHE_WRITEBACK_EN
               clear_selected_dirty_bit = 1'b1;
`endif
            end
         end
         RESPOND: begin
            rsp_valid = 1'b1;
            rsp_err   = err_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_controller.sv
// Randomized bench for cache_controller with metadata/data/memory models.
// Expectations come from a line-residency model of the cache.
module tb_cache_controller;

   localparam int NS = 4;
   localparam int SS = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TS = AW - SS;
`ifdef CACHE_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   logic          clk;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_err;
   logic [SS-1:0] set;
   logic [TS-1:0] tag;
   logic          clear_selected_valid_bit;
   logic          finish_new_line_install;
   logic          clear_selected_dirty_bit;
   logic          set_selected_dirty_bit;
   logic          valid_block_match;
   logic          valid_dirty_bit;
   logic [TS-1:0] selected_tag;
   logic          data_wr_en;
   logic          data_wr_src;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_we;
   logic [AW-1:0] mem_req_addr;
   logic          mem_rsp_valid;

   cache_controller dut (
      .clk                      (clk),
      .reset_n                  (reset_n),
      .req_valid                (req_valid),
      .req_ready                (req_ready),
      .req_we                   (req_we),
      .req_addr                 (req_addr),
      .req_wdata                (req_wdata),
      .rsp_valid                (rsp_valid),
      .rsp_err                  (rsp_err),
      .set                      (set),
      .tag                      (tag),
      .clear_selected_valid_bit (clear_selected_valid_bit),
      .finish_new_line_install  (finish_new_line_install),
      .clear_selected_dirty_bit (clear_selected_dirty_bit),
      .set_selected_dirty_bit   (set_selected_dirty_bit),
      .valid_block_match        (valid_block_match),
      .valid_dirty_bit          (valid_dirty_bit),
      .selected_tag             (selected_tag),
      .data_wr_en               (data_wr_en),
      .data_wr_src              (data_wr_src),
      .mem_req_valid            (mem_req_valid),
      .mem_req_ready            (mem_req_ready),
      .mem_req_we               (mem_req_we),
      .mem_req_addr             (mem_req_addr),
      .mem_rsp_valid            (mem_rsp_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 5) return 32'hCAFE_0001;
      return 32'hA5A5_0000 | i;
   endfunction

   // Environment: metadata array, data array, main memory.
   logic          mv [NS];
   logic          md [NS];
   logic [TS-1:0] mt [NS];
   logic [DW-1:0] cd [NS];
   logic [DW-1:0] mem [64];
   logic          mem_inited = 1'b0;
   logic [DW-1:0] mem_rdata;
   logic          pend;
   int            pcnt;
   logic [AW-1:0] paddr;
   logic          pwe;
   logic          force_stall = 1'b0;
   logic          hold_rsp = 1'b0;
   logic          stray_rsp = 1'b0;
   int            excl_err = 0;

   assign valid_block_match = mv[set] && (mt[set] == tag);
   assign valid_dirty_bit   = mv[set] && md[set];
   assign selected_tag      = mt[set];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NS; i++) begin
            mv[i] <= 1'b0;
            md[i] <= 1'b0;
            mt[i] <= '0;
         end
      end else begin
         if (clear_selected_valid_bit) mv[set] <= 1'b0;
         if (finish_new_line_install) begin
            mv[set] <= 1'b1;
            mt[set] <= tag;
         end
         if (clear_selected_dirty_bit) md[set] <= 1'b0;
         if (set_selected_dirty_bit) md[set] <= 1'b1;
         if (data_wr_en)
            cd[set] <= data_wr_src ? mem_rdata : req_wdata;
         if ((clear_selected_valid_bit && finish_new_line_install) ||
             (clear_selected_dirty_bit && set_selected_dirty_bit))
            excl_err <= excl_err + 1;
      end
   end

   initial mem_req_ready = 1'b0;
   always @(posedge clk)
      mem_req_ready <= force_stall ? 1'b0 : 1'($urandom_range(0, 1));

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend          <= 1'b0;
         pcnt          <= 0;
         mem_rsp_valid <= 1'b0;
         if (!mem_inited) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
            mem_inited <= 1'b1;
         end
      end else begin
         mem_rsp_valid <= stray_rsp;
         if (mem_req_valid && mem_req_ready && !pend) begin
            pend  <= 1'b1;
            pcnt  <= $urandom_range(0, 3);
            paddr <= mem_req_addr;
            pwe   <= mem_req_we;
            if (mem_req_we) mem[mem_req_addr[5:0]] <= cd[set];
         end
         if (pend && !hold_rsp) begin
            if (pcnt == 0) begin
               mem_rsp_valid <= 1'b1;
               pend          <= 1'b0;
               if (!pwe) mem_rdata <= mem[paddr[5:0]];
            end else
               pcnt <= pcnt - 1;
         end
      end
   end

   // Reference model: which word each set holds, its dirtiness, CPU-visible values.
   logic          rv [NS];
   logic [AW-1:0] ra [NS];
   logic          rd [NS];
   logic [DW-1:0] ref_val [64];

   task automatic ref_reset();
      for (int i = 0; i < NS; i++) begin
         rv[i] = 1'b0;
         rd[i] = 1'b0;
         ra[i] = '0;
      end
   endtask

   task automatic do_req(input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int stall_n);
      int s, k, lat, wr_cnt, fin_cnt, stall_left, wr_exp;
      logic hit, err_exp, wb_exp, got, err_got, st_ok;
      logic [AW-1:0] victim;
      logic [AW:0] a0;
      logic [AW:0] exp_q[$];
      logic [AW:0] got_q[$];
      s = int'(a[1:0]);
      hit = rv[s] && (ra[s] == a);
      err_exp = !WB && we;
      wb_exp = 1'b0;
      victim = ra[s];
      if (!err_exp && !hit) begin
         if (WB && rv[s] && rd[s]) begin
            wb_exp = 1'b1;
            exp_q.push_back({1'b1, victim});
         end
         exp_q.push_back({1'b0, a});
      end
      wr_exp = err_exp ? 0 : (hit ? 0 : 1) + (we ? 1 : 0);
      force_stall = (stall_n > 0);
      stall_left = stall_n;
      a0 = '0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_idle got %b want 1", req_ready);
      end
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0;
      k = 1; got = 1'b0; lat = 0; err_got = 1'b0;
      wr_cnt = 0; fin_cnt = 0; st_ok = 1'b0;
      while (!got && k < 400) begin
         if (mem_req_valid && stall_left > 0) begin
            if (stall_left == stall_n)
               a0 = {mem_req_we, mem_req_addr};
            else begin
               checks++;
               if ({mem_req_we, mem_req_addr} !== a0 || mem_req_ready !== 1'b0) begin
                  errors++;
                  $display("FAIL stall_stable got %h want %h", {mem_req_we, mem_req_addr}, a0);
               end
            end
            stall_left--;
            if (stall_left == 0) force_stall = 1'b0;
         end
         if (mem_req_valid && mem_req_ready)
            got_q.push_back({mem_req_we, mem_req_addr});
         if (data_wr_en) wr_cnt++;
         if (finish_new_line_install) fin_cnt++;
         if (k == 1 && data_wr_en && !data_wr_src && set_selected_dirty_bit)
            st_ok = 1'b1;
         if (rsp_valid) begin
            got = 1'b1;
            lat = k;
            err_got = rsp_err;
         end else begin
            @(negedge clk);
            k++;
         end
      end
      force_stall = 1'b0;
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL rsp_timeout addr %h got none want rsp_valid", a);
      end
      checks++;
      if (err_got !== err_exp) begin
         errors++;
         $display("FAIL rsp_err addr %h got %b want %b", a, err_got, err_exp);
      end
      checks++;
      if (got_q.size() != exp_q.size() || got_q != exp_q) begin
         errors++;
         $display("FAIL mem_traffic addr %h got %p want %p", a, got_q, exp_q);
      end
      checks++;
      if (wr_cnt != wr_exp || fin_cnt != ((!err_exp && !hit) ? 1 : 0)) begin
         errors++;
         $display("FAIL wr_install addr %h got %0d/%0d want %0d/%0d",
                  a, wr_cnt, fin_cnt, wr_exp, (!err_exp && !hit) ? 1 : 0);
      end
      if (hit && !err_exp) begin
         checks++;
         if (lat != 2) begin
            errors++;
            $display("FAIL hit_latency addr %h got %0d want 2", a, lat);
         end
      end
      if (err_exp) begin
         checks++;
         if (lat > 2) begin
            errors++;
            $display("FAIL err_latency addr %h got %0d want <=2", a, lat);
         end
      end
      if (hit && we && !err_exp) begin
         checks++;
         if (!st_ok) begin
            errors++;
            $display("FAIL store_hit_lookup addr %h got 0 want 1", a);
         end
      end
      if (!err_exp) begin
         rv[s] = 1'b1;
         ra[s] = a;
         if (!hit) rd[s] = 1'b0;
         if (we) begin
            ref_val[a[5:0]] = wd;
            rd[s] = 1'b1;
         end
         checks++;
         if (mv[s] !== 1'b1 || mt[s] !== a[AW-1:SS] || md[s] !== rd[s] ||
             cd[s] !== ref_val[a[5:0]]) begin
            errors++;
            $display("FAIL line_state addr %h got v%b t%h d%b %h want v1 t%h d%b %h",
                     a, mv[s], mt[s], md[s], cd[s], a[AW-1:SS], rd[s], ref_val[a[5:0]]);
         end
      end
      if (wb_exp) begin
         checks++;
         if (mem[victim[5:0]] !== ref_val[victim[5:0]]) begin
            errors++;
            $display("FAIL writeback_data addr %h got %h want %h",
                     victim, mem[victim[5:0]], ref_val[victim[5:0]]);
         end
      end
   endtask

   task automatic chk_quiet(input string nm);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s_ready got %b want 1", nm, req_ready);
      end
      checks++;
      if ({mem_req_valid, mem_req_we, mem_req_addr, rsp_valid, rsp_err, data_wr_en,
           data_wr_src, clear_selected_valid_bit, finish_new_line_install,
           clear_selected_dirty_bit, set_selected_dirty_bit, set, tag} !== '0) begin
         errors++;
         $display("FAIL %s_outputs got nonzero want 0 (mrv %b addr %h set %h tag %h)",
                  nm, mem_req_valid, mem_req_addr, set, tag);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      ref_reset();
      for (int i = 0; i < 64; i++) ref_val[i] = init_val(i);
      repeat (2) @(negedge clk);
      chk_quiet("reset");
      reset_n = 1'b1;
      @(negedge clk);
      chk_quiet("post_reset");
   endtask

   task automatic test_reset_mid_miss();
      logic hs, in_wait;
      hs = 1'b0; in_wait = 1'b0;
      hold_rsp = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h2; req_wdata = '0;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 0; k < 200 && !in_wait; k++) begin
         @(negedge clk);
         if (hs && !mem_req_valid) in_wait = 1'b1;
         if (mem_req_valid && mem_req_ready) hs = 1'b1;
      end
      checks++;
      if (!in_wait) begin
         errors++;
         $display("FAIL fill_wait_reach got 0 want 1");
      end
      reset_n = 1'b0;
      #1;
      chk_quiet("mid_miss_reset");
      @(negedge clk);
      hold_rsp = 1'b0;
      reset_n = 1'b1;
      ref_reset();
      repeat (3) @(negedge clk);
      chk_quiet("after_abandon");
   endtask

   task automatic test_stray_rsp();
      @(negedge clk);
      stray_rsp = 1'b1;
      @(negedge clk);
      stray_rsp = 1'b0;
      checks++;
      if (mem_rsp_valid !== 1'b1) begin
         errors++;
         $display("FAIL stray_inject got %b want 1", mem_rsp_valid);
      end
      chk_quiet("stray_rsp");
      @(negedge clk);
      chk_quiet("stray_after");
   endtask

   task automatic test_directed();
      do_req(1'b0, 32'h5, 32'h0, 0);
      checks++;
      if (cd[1] !== 32'hCAFE_0001) begin
         errors++;
         $display("FAIL cold_read_data got %h want cafe0001", cd[1]);
      end
      do_req(1'b0, 32'h5, 32'h0, 0);
      do_req(1'b1, 32'h5, 32'h1234, 0);
      do_req(1'b0, 32'h9, 32'h0, 0);
      do_req(1'b0, 32'h3, 32'h0, 6);
      do_req(1'b1, 32'h5, 32'hBEEF, 6);
   endtask

   task automatic test_random();
      for (int i = 0; i < 80; i++) begin
         do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_exclusive();
      checks++;
      if (excl_err != 0) begin
         errors++;
         $display("FAIL pulse_exclusive got %0d want 0", excl_err);
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_miss();
      test_stray_rsp();
      test_directed();
      test_random();
      test_exclusive();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
